// File: rtl/alu_cmd_pkg.sv
// ---------------------------------------------------------------------------
// alu_cmd_pkg
// Shared types and constants for the ALU command sequencer:
//   - state_e     : frame sequencer states
//   - *_BYTES     : frame geometry (1 opcode byte + two 4-byte operands)
//   - get_byte / put_byte : little-endian byte lane helpers for 32-bit words
// ---------------------------------------------------------------------------
package alu_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RX_A    = 3'd1,
    RX_B    = 3'd2,
    EXEC    = 3'd3,
    TX_WAIT = 3'd4
  } state_e;

  localparam int unsigned OPERAND_BYTES = 4;
  localparam int unsigned RESULT_BYTES  = 4;
  localparam int unsigned FRAME_BYTES   = 1 + 2 * OPERAND_BYTES;

  localparam logic [1:0] LAST_OPERAND_IDX = 2'(OPERAND_BYTES - 1);
  localparam logic [1:0] LAST_RESULT_IDX  = 2'(RESULT_BYTES - 1);

  // Byte lane idx of a little-endian 32-bit word.
  function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

  // Returns word with byte lane idx replaced by b.
  function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] w;
    w = word;
    w[{idx, 3'b000} +: 8] = b;
    return w;
  endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// ---------------------------------------------------------------------------
// cmd_timeout_timer
// Inter-byte watchdog for the command sequencer. Counts enabled cycles since
// the last clear; expire is high while enabled once TIMEOUT_CYCLES cycles
// have elapsed without a clear. Only built when CMD_TIMEOUT_EN is defined.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   clear        : restart the count (a byte arrived)
//   enable       : count only while a frame is being received
//   expire       : abort request to the sequencer
// ---------------------------------------------------------------------------
module cmd_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 32'd2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 32'd1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: a clear or leaving the receive states restarts from zero.
  always_comb begin
    count_d = count_q;
    if (clear || !enable) begin
      count_d = {CNT_W{1'b0}};
    end else begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  // Expire is not masked by clear: a byte on the expiry cycle starts a new frame.
  assign expire = enable && (count_q == LAST_CNT);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
// Frame controller between UART RX/TX and a 32-bit ALU. Collects a 9-byte
// frame (opcode, A[7:0..31:24], B[7:0..31:24]) into shadow registers, commits
// them to the ALU operands atomically on the last byte, lets the ALU settle
// for one cycle, then returns the 32-bit result as 4 little-endian bytes via
// the tx_start/tx_done handshake.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   d_in, rx_done     : received byte and its one-cycle strobe
//   tx_done           : transmitter finished the current byte
//   d_out_ALU         : combinational ALU result for A/B/opcode
//   d_out, tx_start   : byte to transmit and its one-cycle start pulse
//   A, B, opcode      : registered ALU operands
//   busy              : frame in progress (first byte to last tx_done)
// Build option:
//   CMD_TIMEOUT_EN    : abort partial frames after TIMEOUT_CYCLES idle cycles
// ---------------------------------------------------------------------------
module alu_cmd_sequencer
  import alu_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  d_in,
  input  logic        rx_done,
  input  logic        tx_done,
  input  logic [31:0] d_out_ALU,
  output logic [7:0]  d_out,
  output logic        tx_start,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [7:0]  opcode,
  output logic        busy
);

  state_e      state_q,    state_d;
  logic [1:0]  idx_q,      idx_d;
  logic [7:0]  sh_op_q,    sh_op_d;
  logic [31:0] sh_a_q,     sh_a_d;
  logic [31:0] sh_b_q,     sh_b_d;
  logic [31:0] res_q,      res_d;
  logic [31:0] a_q,        a_d;
  logic [31:0] b_q,        b_d;
  logic [7:0]  opcode_q,   opcode_d;
  logic [7:0]  d_out_q,    d_out_d;
  logic        tx_start_q, tx_start_d;
  logic        busy_q,     busy_d;

  logic        expire_s;

`ifdef CMD_TIMEOUT_EN
  logic timer_en_s;

  assign timer_en_s = (state_q == RX_A) || (state_q == RX_B);

  cmd_timeout_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (rx_done),
    .enable (timer_en_s),
    .expire (expire_s)
  );
`else
  logic unused_timeout_s;

  assign unused_timeout_s = (TIMEOUT_CYCLES > 32'd1);
  assign expire_s         = 1'b0;
`endif

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sh_op_d    = sh_op_q;
    sh_a_d     = sh_a_q;
    sh_b_d     = sh_b_q;
    res_d      = res_q;
    a_d        = a_q;
    b_d        = b_q;
    opcode_d   = opcode_q;
    d_out_d    = d_out_q;
    tx_start_d = 1'b0;
    busy_d     = busy_q;

    if (expire_s) begin
      // Abort the partial frame; a coincident byte opens the next frame.
      sh_a_d = 32'd0;
      sh_b_d = 32'd0;
      idx_d  = 2'd0;
      if (rx_done) begin
        sh_op_d = d_in;
        busy_d  = 1'b1;
        state_d = RX_A;
      end else begin
        sh_op_d = 8'd0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_done) begin
            sh_op_d = d_in;
            busy_d  = 1'b1;
            idx_d   = 2'd0;
            state_d = RX_A;
          end else begin
            busy_d  = 1'b0;
          end
        end

        RX_A: begin
          if (rx_done) begin
            sh_a_d = put_byte(sh_a_q, idx_q, d_in);
            if (idx_q == LAST_OPERAND_IDX) begin
              idx_d   = 2'd0;
              state_d = RX_B;
            end else begin
              idx_d   = idx_q + 2'd1;
            end
          end else begin
            state_d = RX_A;
          end
        end

        RX_B: begin
          if (rx_done) begin
            sh_b_d = put_byte(sh_b_q, idx_q, d_in);
            if (idx_q == LAST_OPERAND_IDX) begin
              // Whole frame present: commit all operands on the same edge.
              a_d      = sh_a_q;
              b_d      = put_byte(sh_b_q, idx_q, d_in);
              opcode_d = sh_op_q;
              idx_d    = 2'd0;
              state_d  = EXEC;
            end else begin
              idx_d    = idx_q + 2'd1;
            end
          end else begin
            state_d = RX_B;
          end
        end

        EXEC: begin
          res_d      = d_out_ALU;
          d_out_d    = d_out_ALU[7:0];
          tx_start_d = 1'b1;
          idx_d      = 2'd0;
          state_d    = TX_WAIT;
        end

        TX_WAIT: begin
          // rx_done is deliberately ignored here; tx_done has priority.
          if (tx_done) begin
            if (idx_q == LAST_RESULT_IDX) begin
              busy_d  = 1'b0;
              idx_d   = 2'd0;
              state_d = IDLE;
            end else begin
              idx_d      = idx_q + 2'd1;
              d_out_d    = get_byte(res_q, idx_q + 2'd1);
              tx_start_d = 1'b1;
            end
          end else begin
            tx_start_d = 1'b0;
          end
        end

        default: begin
          state_d = IDLE;
          idx_d   = 2'd0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset is asynchronous so tx_start drops at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      sh_op_q    <= 8'd0;
      sh_a_q     <= 32'd0;
      sh_b_q     <= 32'd0;
      res_q      <= 32'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      opcode_q   <= 8'd0;
      d_out_q    <= 8'd0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sh_op_q    <= sh_op_d;
      sh_a_q     <= sh_a_d;
      sh_b_q     <= sh_b_d;
      res_q      <= res_d;
      a_q        <= a_d;
      b_q        <= b_d;
      opcode_q   <= opcode_d;
      d_out_q    <= d_out_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
    end
  end

  assign d_out    = d_out_q;
  assign tx_start = tx_start_q;
  assign A        = a_q;
  assign B        = b_q;
  assign opcode   = opcode_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_sequencer
// Directed frames with hand-computed results. Expected transmit bytes go into
// a queue when a frame is issued; a negedge monitor pops and compares on every
// tx_start. The ALU is modelled here: 0x20 -> A+B, 0x30 -> 0xDEADBEEF,
// anything else -> A^B.
// ---------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

  logic        clk;
  logic        reset;
  logic [7:0]  d_in;
  logic        rx_done;
  logic        tx_done;
  logic [31:0] d_out_alu;
  logic [7:0]  d_out;
  logic        tx_start;
  logic [31:0] a;
  logic [31:0] b;
  logic [7:0]  opcode;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  int          tx_starts = 0;
  logic        prev_start = 1'b0;
  logic [7:0]  mon_exp;
  logic [7:0]  exp_q[$];

  alu_cmd_sequencer #(
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .d_in      (d_in),
    .rx_done   (rx_done),
    .tx_done   (tx_done),
    .d_out_ALU (d_out_alu),
    .d_out     (d_out),
    .tx_start  (tx_start),
    .A         (a),
    .B         (b),
    .opcode    (opcode),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model
  always_comb begin
    if (opcode == 8'h20)      d_out_alu = a + b;
    else if (opcode == 8'h30) d_out_alu = 32'hDEADBEEF;
    else                      d_out_alu = a ^ b;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every transmitted byte is compared against the scoreboard.
  always @(negedge clk) begin
    if (reset && tx_start) begin
      tx_starts++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: got byte 0x%0h expected none", d_out);
      end else begin
        mon_exp = exp_q.pop_front();
        check("tx_byte", {24'd0, d_out}, {24'd0, mon_exp});
      end
      check("tx_start_single_cycle", {31'd0, prev_start}, 32'd0);
    end
    prev_start = reset ? tx_start : 1'b0;
  end

  task automatic push_result(input logic [31:0] r);
    for (int i = 0; i < 4; i++) exp_q.push_back(r[8*i +: 8]);
  endtask

  task automatic rx_byte(input logic [7:0] v);
    @(negedge clk);
    d_in    = v;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] av, input logic [31:0] bv);
    rx_byte(op);
    for (int i = 0; i < 4; i++) rx_byte(av[8*i +: 8]);
    for (int i = 0; i < 4; i++) rx_byte(bv[8*i +: 8]);
  endtask

  task automatic wait_tx_start(input string name);
    int n;
    n = 0;
    while (!tx_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!tx_start) begin
      checks++;
      errors++;
      $display("FAIL %s: tx_start got 0 expected 1 within 50 cycles", name);
    end
  endtask

  // Plays the transmitter for 4 bytes; can inject a stray byte mid-byte
  // (inject_k) or coincident with tx_done (coincide_k).
  task automatic serve_tx(input int inject_k, input int coincide_k);
    logic [7:0] held;
    for (int k = 0; k < 4; k++) begin
      wait_tx_start("tx_start_wait");
      held = d_out;
      @(negedge clk);
      if (k == inject_k) begin
        d_in    = 8'h55;
        rx_done = 1'b1;
      end
      @(negedge clk);
      rx_done = 1'b0;
      @(negedge clk);
      check("d_out_stable", {24'd0, d_out}, {24'd0, held});
      check("busy_during_tx", {31'd0, busy}, 32'd1);
      tx_done = 1'b1;
      if (k == coincide_k) begin
        d_in    = 8'h77;
        rx_done = 1'b1;
      end
      @(negedge clk);
      tx_done = 1'b0;
      rx_done = 1'b0;
      if (k < 3) check("tx_start_after_tx_done", {31'd0, tx_start}, 32'd1);
      else       check("busy_after_last_tx_done", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int snap;
    reset   = 1'b0;
    rx_done = 1'b0;
    tx_done = 1'b0;
    d_in    = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_d_out",    {24'd0, d_out},    32'd0);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_A",        a,                 32'd0);
    check("rst_B",        b,                 32'd0);
    check("rst_opcode",   {24'd0, opcode},   32'd0);
    check("rst_busy",     {31'd0, busy},     32'd0);
    reset = 1'b1;
    @(negedge clk);

    // tx_done while idle is ignored
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check("idle_tx_done_busy",  {31'd0, busy},     32'd0);
    check("idle_tx_done_start", {31'd0, tx_start}, 32'd0);

    // Basic add frame with latency checks
    push_result(32'h0000_0008);
    send_frame(8'h20, 32'd5, 32'd3);
    check("add_A",      a,                 32'd5);
    check("add_B",      b,                 32'd3);
    check("add_opcode", {24'd0, opcode},   32'h20);
    check("exec_no_tx", {31'd0, tx_start}, 32'd0);
    check("add_busy",   {31'd0, busy},     32'd1);
    @(negedge clk);
    check("tx_start_latency", {31'd0, tx_start}, 32'd1);
    serve_tx(-1, -1);

    // Byte order, and operands held during a partial frame
    push_result(32'hDEADBEEF);
    rx_byte(8'h30);
    rx_byte(8'h78); rx_byte(8'h56); rx_byte(8'h34); rx_byte(8'h12);
    check("partial_A_held",      a,               32'd5);
    check("partial_opcode_held", {24'd0, opcode}, 32'h20);
    rx_byte(8'h01); rx_byte(8'h00); rx_byte(8'h00); rx_byte(8'h00);
    check("order_A",      a,               32'h12345678);
    check("order_B",      b,               32'd1);
    check("order_opcode", {24'd0, opcode}, 32'h30);
    serve_tx(-1, -1);

    // Stray byte during TX_WAIT is dropped
    push_result(32'h0000_0123);
    send_frame(8'h20, 32'h100, 32'h23);
    serve_tx(1, -1);
    check("inject_A_kept", a, 32'h100);
    push_result(32'h0000_0003);
    send_frame(8'h20, 32'd1, 32'd2);
    check("after_inject_A", a, 32'd1);
    check("after_inject_B", b, 32'd2);
    serve_tx(-1, -1);

    // rx_done coincident with tx_done
    push_result(32'h11223344);
    send_frame(8'h20, 32'h01020304, 32'h10203040);
    serve_tx(-1, 1);
    check("coincide_opcode", {24'd0, opcode}, 32'h20);
    check("coincide_busy",   {31'd0, busy},   32'd0);

    // Reset during the second result byte
    push_result(32'hFFFF_FFF0);
    send_frame(8'h40, 32'hF0F0F0F0, 32'h0F0F0F00);
    wait_tx_start("rst_first_start");
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    wait_tx_start("rst_second_start");
    #2 reset = 1'b0;
    #1;
    check("async_rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("async_rst_d_out",    {24'd0, d_out},    32'd0);
    check("async_rst_A",        a,                 32'd0);
    check("async_rst_B",        b,                 32'd0);
    check("async_rst_opcode",   {24'd0, opcode},   32'd0);
    check("async_rst_busy",     {31'd0, busy},     32'd0);
    exp_q.delete();
    snap = tx_starts;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("no_tx_after_reset", tx_starts, snap);
    push_result(32'h0000_000F);
    send_frame(8'h20, 32'd7, 32'd8);
    check("post_rst_A", a, 32'd7);
    serve_tx(-1, -1);

`ifdef CMD_TIMEOUT_EN
    // Partial frame aborted after 100 idle cycles
    rx_byte(8'h20); rx_byte(8'h11); rx_byte(8'h22);
    repeat (99) @(negedge clk);
    check("timeout_not_yet", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("timeout_busy", {31'd0, busy}, 32'd0);
    check("timeout_A",    a,             32'd7);
    check("timeout_B",    b,             32'd8);
    push_result(32'h0000_0004);
    send_frame(8'h20, 32'd2, 32'd2);
    check("after_timeout_A", a, 32'd2);
    serve_tx(-1, -1);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
